fir_seq_ctrl: RTL and testbench
===============================

# fir_seq_ctrl

Sequencer for a time-multiplexed FIR filter: one shared signed multiply-accumulate unit stepped across all taps per input sample, replacing the fully parallel 4-tap datapath where area matters. Accepts samples on a valid/ready handshake, owns the delay line and the writable coefficient bank, and emits one filtered result per accepted sample. Sits between the sample source and the downstream consumer of `Yout`.

## Interface
- `TAPS`, 4, number of filter taps (≥2)
- `XW`, 8, signed sample and coefficient width
- `YW`, 16, signed output width
- `Clk`  in  1  single clock, rising edge
- `Rst_n`  in  1  asynchronous, active-low reset
- `Xin`  in  XW  signed input sample
- `Xin_valid`  in  1  sample offered
- `Xin_ready`  out  1  block can accept a sample
- `Coef_we`  in  1  coefficient write strobe
- `Coef_addr`  in  clog2(TAPS)  tap index; tap 0 multiplies the newest sample
- `Coef_data`  in  XW  signed coefficient
- `Coef_busy`  out  1  coefficient writes are being ignored
- `Yout`  out  YW  signed filter result, held until the next result
- `Yout_valid`  out  1  one-cycle pulse when `Yout` updates

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE: `Xin_ready`=1. On `Xin_valid && Xin_ready`:
  - shift `Xin` into `dl[0]` and move `dl[i]` to `dl[i+1]`;
  - clear the accumulator;
  - set the tap index to 0;
  - go to MAC.
- MAC: each cycle `acc += coef[idx] * dl[idx]` and `idx++`. After TAPS cycles, go to DONE.
- DONE: `Yout` ← reduce(acc), `Yout_valid` ← 1 for one cycle, go to IDLE.
- Arithmetic:
  - product is 2·XW bits signed;
  - accumulator is 2·XW + clog2(TAPS) bits signed, so it never overflows internally;
  - the reduction to YW bits is set by the configuration macro.
- `Xin_ready` and `Coef_busy` are decoded from the state register only: `Xin_ready`=(state==IDLE), `Coef_busy`=(state!=IDLE).
- `Coef_we` takes effect only in IDLE. It is silently dropped otherwise. Software polls `Coef_busy`.
- A coefficient write and a sample accept in the same IDLE cycle are both performed. The new coefficient is used for that sample.
- `Xin_valid` outside IDLE is ignored. The source must hold the sample until ready.
- Reset values:
  - state IDLE, `Xin_ready` 1, `Coef_busy` 0;
  - `Yout` 0, `Yout_valid` 0;
  - all `dl[i]` 0;
  - all `coef[i]` = +1 (moving sum).
- Reset asserted mid-MAC aborts the sample. All of the above reset values apply immediately and no `Yout_valid` is produced.

## Timing
- Sample accepted at edge k → MAC at edges k+1 … k+TAPS → `Yout`/`Yout_valid` registered at edge k+TAPS+1.
- `Xin_ready` returns high in that same cycle.
- Latency TAPS+1 cycles. Maximum throughput is one sample per TAPS+2 cycles (6 at default).
- `Yout_valid` is never high for two consecutive cycles.

## Configuration
- `FIR_SAT_EN` defined:
  - acc > 2^(YW−1)−1 → `Yout` = 0x7FFF (at YW=16);
  - acc < −2^(YW−1) → `Yout` = 0x8000;
  - otherwise `Yout` = low YW bits of acc.
- `FIR_SAT_EN` undefined: `Yout` = low YW bits of acc (two's-complement wrap). No extra logic.

## Structure
- Package `fir_pkg` holds:
  - width constants XW, YW, ACCW;
  - the FSM state typedef/encoding (IDLE, MAC, DONE);
  - the saturation function.
- Sub-module `fir_mac`:
  - signed XW×XW multiply plus ACCW accumulator;
  - inputs clr and en;
  - instantiated once.
- Controller FSM, delay line and coefficient register file live in `fir_seq_ctrl`.

## Test plan
- Reset coefs (all +1), `Xin` stream 0, −3, 1, 0, −2 each held until accepted → `Yout` 0, −3, −2, −2, −4, each with a single `Yout_valid` pulse 5 cycles after accept.
- Write coefs {2, −1, 0, 0} in IDLE, after reset, then `Xin` 4, −5, 6 → `Yout` 8, −14, 17.
- Stress with coefs all 127 and four `Xin` = −128 (final acc −65024):
  - with `FIR_SAT_EN`, 4th `Yout` = 0x8000;
  - without it, 4th `Yout` = 0x0200.
- `Coef_we` pulsed during MAC (`Coef_busy`=1) with data 0 to tap 0 → write dropped; next result still uses coef 1.
- `Xin_valid` held high continuously → accepts exactly every 6 cycles; `Xin_ready` low for 5 cycles after each accept.
- `Rst_n` asserted at the 2nd MAC cycle → `Yout` = 0, no `Yout_valid`, `Xin_ready` = 1 from reset onward; after release, `Xin` = 7 → `Yout` = 7 (delay line cleared).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding and output saturation for the time-multiplexed FIR.
package fir_pkg;

   localparam int unsigned TAPS = 4;
   localparam int unsigned XW   = 8;
   localparam int unsigned YW   = 16;
   localparam int unsigned IDXW = $clog2(TAPS);
   localparam int unsigned ACCW = 2 * XW + IDXW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Clamp the accumulator to the signed YW-bit output range.
   function automatic logic [YW-1:0] sat_acc(input logic signed [ACCW-1:0] a);
      logic [ACCW-YW:0] hi;
      hi = a[ACCW-1:YW-1];
      if ((hi == '0) || (hi == '1)) return a[YW-1:0];
      else if (a[ACCW-1])          return {1'b1, {(YW-1){1'b0}}};
      else                         return {1'b0, {(YW-1){1'b1}}};
   endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample, coefficient and result signals of the FIR sequencer.
interface fir_seq_ctrl_if
   import fir_pkg::*;
();
   logic [XW-1:0]   Xin;
   logic            Xin_valid;
   logic            Xin_ready;
   logic            Coef_we;
   logic [IDXW-1:0] Coef_addr;
   logic [XW-1:0]   Coef_data;
   logic            Coef_busy;
   logic [YW-1:0]   Yout;
   logic            Yout_valid;

   modport master (
      output Xin, Xin_valid, Coef_we, Coef_addr, Coef_data,
      input  Xin_ready, Coef_busy, Yout, Yout_valid
   );

   modport slave (
      input  Xin, Xin_valid, Coef_we, Coef_addr, Coef_data,
      output Xin_ready, Coef_busy, Yout, Yout_valid
   );
endinterface

// File: rtl/fir_mac.sv
// Shared signed multiply-accumulate unit; wide enough that TAPS products never overflow.
module fir_mac
   import fir_pkg::*;
(
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   clr,
   input  logic                   en,
   input  logic signed [XW-1:0]   a,
   input  logic signed [XW-1:0]   b,
   output logic signed [ACCW-1:0] acc
);

   logic signed [2*XW-1:0] prod;

   assign prod = a * b;

   // Clear at sample accept, accumulate one tap per enabled cycle.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)  acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc + ACCW'(prod);
   end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Time-multiplexed FIR sequencer: delay line, coefficient bank and IDLE/MAC/DONE control.
// Optional macro FIR_SAT_EN: saturate the result to YW bits instead of wrapping.
module fir_seq_ctrl
   import fir_pkg::*;
(
   input logic           Clk,
   input logic           Rst_n,
   fir_seq_ctrl_if.slave bus
);

   state_t                state;
   logic signed [XW-1:0]  dl   [TAPS];
   logic signed [XW-1:0]  coef [TAPS];
   logic [IDXW-1:0]       idx;
   logic [YW-1:0]         yout;
   logic                  yout_valid;
   logic signed [ACCW-1:0] acc;
   logic                  accept_c;
   logic                  mac_en_c;

   assign accept_c       = (state == IDLE) && bus.Xin_valid;
   assign mac_en_c       = (state == MAC);
   assign bus.Xin_ready  = (state == IDLE);
   assign bus.Coef_busy  = (state != IDLE);
   assign bus.Yout       = yout;
   assign bus.Yout_valid = yout_valid;

   fir_mac u_mac (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .clr   (accept_c),
      .en    (mac_en_c),
      .a     (coef[idx]),
      .b     (dl[idx]),
      .acc   (acc)
   );

   // Controller FSM with delay line, coefficient bank and registered result.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         yout       <= '0;
         yout_valid <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            dl[i]   <= '0;
            coef[i] <= XW'(1);
         end
      end else begin
         yout_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.Coef_we && (32'(bus.Coef_addr) < TAPS))
                  coef[bus.Coef_addr] <= bus.Coef_data;
               if (bus.Xin_valid) begin
                  dl[0] <= bus.Xin;
                  for (int i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
                  idx   <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               idx <= idx + IDXW'(1);
               if (idx == IDXW'(TAPS - 1)) state <= DONE;
            end
            DONE: begin
`ifdef FIR_SAT_EN
               yout <= sat_acc(acc);
`else
               yout <= acc[YW-1:0];
`endif
               yout_valid <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: directed scenarios plus random traffic vs. a sum-of-products model.
module tb_fir_seq_ctrl;
   import fir_pkg::*;

   typedef struct {
      int            due;
      logic [YW-1:0] val;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst_n;

   fir_seq_ctrl_if bus();

   fir_seq_ctrl dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   // Reference model state
   int            hist  [TAPS];
   int            mcoef [TAPS];
   exp_t          exp_q [$];
   logic [YW-1:0] cur_y;
   int            free_at;
   int            n_acc = 0;
   logic [YW-1:0] obs_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < TAPS; i++) begin
         hist[i]  = 0;
         mcoef[i] = 1;
      end
      exp_q.delete();
      cur_y   = '0;
      free_at = 0;
   endtask

   // Filter output from the newest TAPS samples, reduced to YW bits.
   function automatic logic [YW-1:0] ref_out();
      int s = 0;
      for (int i = 0; i < TAPS; i++) s += mcoef[i] * hist[i];
`ifdef FIR_SAT_EN
      if (s > 32767)       s = 32767;
      else if (s < -32768) s = -32768;
`endif
      return YW'(s);
   endfunction

   // Per-cycle scoreboard, evaluated mid-cycle when inputs and outputs are stable.
   always @(negedge Clk) begin
      bit   rdy;
      bit   vexp;
      exp_t e;
      if (!Rst_n) begin
         model_reset();
         check("rst_yout",       32'(bus.Yout), 32'(0));
         check("rst_yout_valid", 32'(bus.Yout_valid), 32'(0));
         check("rst_xin_ready",  32'(bus.Xin_ready), 32'(1));
         check("rst_coef_busy",  32'(bus.Coef_busy), 32'(0));
      end else begin
         rdy = (cyc >= free_at);
         check("xin_ready", 32'(bus.Xin_ready), 32'(rdy));
         check("coef_busy", 32'(bus.Coef_busy), 32'(!rdy));
         vexp = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         if (vexp) begin
            e     = exp_q.pop_front();
            cur_y = e.val;
         end
         check("yout_valid", 32'(bus.Yout_valid), 32'(vexp));
         check("yout", 32'(bus.Yout), 32'(cur_y));
         if (bus.Yout_valid) obs_q.push_back(bus.Yout);
         if (rdy && bus.Coef_we) mcoef[bus.Coef_addr] = int'($signed(bus.Coef_data));
         if (rdy && bus.Xin_valid) begin
            for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'($signed(bus.Xin));
            e.due   = cyc + int'(TAPS) + 2;
            e.val   = ref_out();
            exp_q.push_back(e);
            free_at = e.due;
            n_acc++;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      tick(2);
      Rst_n = 1'b1;
      tick(1);
   endtask

   task automatic send(input int x);
      int w = 0;
      bus.Xin       = XW'(x);
      bus.Xin_valid = 1'b1;
      while (!bus.Xin_ready && w < 50) begin
         tick();
         w++;
      end
      check("send_ready", 32'(bus.Xin_ready), 32'(1));
      tick();
      bus.Xin_valid = 1'b0;
   endtask

   task automatic write_coef(input int a, input int d);
      bus.Coef_we   = 1'b1;
      bus.Coef_addr = IDXW'(a);
      bus.Coef_data = XW'(d);
      tick();
      bus.Coef_we   = 1'b0;
   endtask

   task automatic check_obs(input string tag, input int e [5], input int n);
      logic [YW-1:0] ev;
      check({tag, "_count"}, 32'(obs_q.size()), 32'(n));
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
         ev = YW'(e[i]);
         check(tag, 32'(obs_q[i]), 32'(ev));
      end
   endtask

   initial begin
      int            e5 [5];
      int            acc0;
      logic [YW-1:0] ev;

      Rst_n         = 1'b0;
      bus.Xin       = '0;
      bus.Xin_valid = 1'b0;
      bus.Coef_we   = 1'b0;
      bus.Coef_addr = '0;
      bus.Coef_data = '0;

      // Default moving-sum coefficients
      do_reset();
      obs_q.delete();
      send(0); send(-3); send(1); send(0); send(-2);
      tick(8);
      e5 = '{0, -3, -2, -2, -4};
      check_obs("movsum", e5, 5);

      // Programmed coefficients {2,-1,0,0}
      do_reset();
      write_coef(0, 2); write_coef(1, -1); write_coef(2, 0); write_coef(3, 0);
      obs_q.delete();
      send(4); send(-5); send(6);
      tick(8);
      e5 = '{8, -14, 17, 0, 0};
      check_obs("coefprog", e5, 3);

      // Accumulator beyond YW range
      do_reset();
      for (int i = 0; i < TAPS; i++) write_coef(i, 127);
      obs_q.delete();
      repeat (4) send(-128);
      tick(8);
      check("stress_count", 32'(obs_q.size()), 32'(4));
`ifdef FIR_SAT_EN
      ev = 16'h8000;
`else
      ev = 16'h0200;
`endif
      if (obs_q.size() > 3) check("stress_y3", 32'(obs_q[3]), 32'(ev));

      // Coefficient write while busy is dropped
      do_reset();
      obs_q.delete();
      send(5);
      tick();
      bus.Coef_we   = 1'b1;
      bus.Coef_addr = '0;
      bus.Coef_data = '0;
      tick(2);
      bus.Coef_we   = 1'b0;
      send(3);
      tick(8);
      e5 = '{5, 8, 0, 0, 0};
      check_obs("busywr", e5, 2);

      // Xin_valid held high: one accept per TAPS+2 cycles
      do_reset();
      acc0          = n_acc;
      bus.Xin_valid = 1'b1;
      repeat (60) begin
         bus.Xin = XW'($urandom);
         tick();
      end
      bus.Xin_valid = 1'b0;
      check("hold_accepts", 32'(n_acc - acc0), 32'(10));
      tick(8);

      // Reset during the second MAC cycle aborts the sample
      do_reset();
      obs_q.delete();
      send(9);
      tick();
      Rst_n = 1'b0;
      tick(2);
      Rst_n = 1'b1;
      tick();
      check("abort_count", 32'(obs_q.size()), 32'(0));
      send(7);
      tick(8);
      e5 = '{7, 0, 0, 0, 0};
      check_obs("after_abort", e5, 1);

      // Random samples, gaps and coefficient writes at any time
      do_reset();
      repeat (400) begin
         bus.Xin_valid = 1'($urandom_range(0, 1));
         bus.Xin       = XW'($urandom);
         bus.Coef_we   = ($urandom_range(0, 3) == 0);
         bus.Coef_addr = IDXW'($urandom);
         bus.Coef_data = XW'($urandom);
         tick();
      end
      bus.Xin_valid = 1'b0;
      bus.Coef_we   = 1'b0;
      tick(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
